// File: rtl/stopwatch_core_if.sv
// Button inputs, mode controls and display/status outputs of the stopwatch core.
// The bench or board top drives through master; the core attaches as slave.
interface stopwatch_core_if;
  logic        btn_ss;
  logic        btn_clr;
  logic        btn_lap;
  logic        down;
  logic [15:0] preset;
  logic [3:0]  num3;
  logic [3:0]  num2;
  logic [3:0]  num1;
  logic [3:0]  num0;
  logic [3:0]  mask;
  logic        running;
  logic        done;

  modport master (
    output btn_ss, btn_clr, btn_lap, down, preset,
    input  num3, num2, num1, num0, mask, running, done
  );

  modport slave (
    input  btn_ss, btn_clr, btn_lap, down, preset,
    output num3, num2, num1, num0, mask, running, done
  );
endinterface

// File: rtl/stopwatch_core.sv
// Up/down stopwatch core: synchronised button pulses, tick divider, bounded counter,
// lap freeze and a blink phase that flashes the display while paused or done.
module stopwatch_core #(
  parameter int unsigned TICK_DIV  = 2500000,
  parameter int unsigned BLINK_DIV = 6250000,
  parameter int unsigned MAX_COUNT = 9999
) (
  input logic             clk,
  input logic             rst,
  stopwatch_core_if.slave sw
);
  localparam logic [23:0] TickLast  = 24'(TICK_DIV - 1);
  localparam logic [23:0] BlinkLast = 24'(BLINK_DIV - 1);
  localparam logic [15:0] MaxCnt    = 16'(MAX_COUNT);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  // Bit order in the button vectors: [0] ss, [1] clr, [2] lap.
  logic [2:0]  btn_raw, s1_q, s2_q, prev_q, armed_q, pulse;
  logic [1:0]  settle_q;
  logic        ss, clr, lap;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d, num_q, preset_clamped;
  logic [23:0] div_q, div_d, blink_q;
  logic        dir_q, dir_d, frz_q, frz_d, phase_q;
  logic        tick, at_term;

  assign btn_raw = {sw.btn_lap, sw.btn_clr, sw.btn_ss};
  assign pulse   = s2_q & ~prev_q & armed_q;
  assign ss      = pulse[0];
  assign clr     = pulse[1];
  assign lap     = pulse[2];

  // A button is armed only once it has been seen low after reset, so a button held
  // through reset release cannot fire until it is released and pressed again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      armed_q  <= '0;
      settle_q <= '0;
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      settle_q <= {settle_q[0], 1'b1};
      armed_q  <= armed_q | ({3{settle_q[1]}} & ~s2_q);
    end
  end

  assign preset_clamped = (sw.preset > MaxCnt) ? MaxCnt : sw.preset;
  assign tick           = (state_q == StRun) && (div_q == TickLast);
  assign at_term        = dir_q ? (count_q == '0) : (count_q >= MaxCnt);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    frz_d   = frz_q;
    div_d   = '0;
    if (clr) begin
      state_d = StIdle;
      dir_d   = sw.down;
      count_d = sw.down ? preset_clamped : 16'd0;
      frz_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  if (ss) state_d = at_term ? StDone : StRun;
        StRun: begin
          if (tick && !dir_q) begin
            if (count_q >= MaxCnt - 16'd1) begin
              count_d = MaxCnt;
              state_d = StDone;
            end else begin
              count_d = count_q + 16'd1;
            end
          end else if (tick) begin
            if (count_q <= 16'd1) begin
              count_d = '0;
              state_d = StDone;
            end else begin
              count_d = count_q - 16'd1;
            end
          end
          // Terminal tick wins over a coincident pause so the bound is never missed.
          if (state_d == StDone) frz_d = 1'b0;
          else if (ss)           state_d = StPause;
          else if (lap)          frz_d = ~frz_q;
        end
        StPause: if (ss) state_d = StRun;
        default: ;
      endcase
    end
    if ((state_q == StRun) && (state_d == StRun)) div_d = tick ? 24'd0 : div_q + 24'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      dir_q   <= 1'b0;
      frz_q   <= 1'b0;
      div_q   <= '0;
      num_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      frz_q   <= frz_d;
      div_q   <= div_d;
      if (!frz_q) num_q <= count_q;
      if (blink_q == BlinkLast) begin
        blink_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        blink_q <= blink_q + 24'd1;
      end
    end
  end

  assign sw.num3    = num_q[15:12];
  assign sw.num2    = num_q[11:8];
  assign sw.num1    = num_q[7:4];
  assign sw.num0    = num_q[3:0];
  assign sw.mask    = ((state_q == StIdle) || (state_q == StRun)) ? 4'hF : {4{phase_q}};
  assign sw.running = (state_q == StRun);
  assign sw.done    = (state_q == StDone);
endmodule
